// File: rtl/sensor_conditioner_if.sv
// Sensor-side signal bundle for the conditioning stage: raw sensor lines in,
// debounced levels and change strobes out.
interface sensor_conditioner_if;
  logic e_raw;
  logic w_raw;
  logic e;
  logic w;
  logic e_chg;
  logic w_chg;

  modport master (
    output e_raw, w_raw,
    input  e, w, e_chg, w_chg
  );

  modport slave (
    input  e_raw, w_raw,
    output e, w, e_chg, w_chg
  );
endinterface

// File: rtl/sensor_conditioner.sv
// Two independent sync + debounce channels (index 0 = east, 1 = west) that
// deliver clean e/w levels and one-cycle change strobes to the sequence FSM.
module sensor_conditioner #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned CNT_W    = 8
) (
  input logic              clk,
  input logic              reset_n,
  sensor_conditioner_if.slave sif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

  logic [1:0]       raw;
  logic [1:0]       s1_q;
  logic [1:0]       s2_q;
  logic [1:0]       lvl_q;
  logic [1:0]       chg_q;
  logic [CNT_W-1:0] cnt_q [2];

  assign raw = {sif.w_raw, sif.e_raw};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      lvl_q <= '0;
      chg_q <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      chg_q <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        // Any agreeing sample restarts qualification, so bounces never leak.
        if (s2_q[i] == lvl_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          lvl_q[i] <= s2_q[i];
          cnt_q[i] <= '0;
          chg_q[i] <= 1'b1;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign sif.e     = lvl_q[0];
  assign sif.w     = lvl_q[1];
  assign sif.e_chg = chg_q[0];
  assign sif.w_chg = chg_q[1];

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: directed timing scenarios plus randomized
// sensor activity, checked against a sliding-window reference model.
module tb_sensor_conditioner;

  localparam int unsigned D = 4;

  logic clk;
  logic reset_n;
  int   tests_run;
  int   fails;

  sensor_conditioner_if sif ();

  sensor_conditioner #(.DEBOUNCE(D), .CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sif     (sif)
  );

  always #5 clk = ~clk;

  // Reference model: a level is adopted once the last D synchronized samples
  // all disagree with the current output.
  bit [1:0]   m_s1, m_s2, m_out, m_chg;
  bit [D-1:0] m_hist [2];
  int         m_fill [2];

  function automatic bit [D-1:0] shift_in(bit [D-1:0] h, bit s);
    return D'({h, s});
  endfunction

  function automatic bit flips(bit [D-1:0] h, bit s, bit out, int fill);
    bit [D-1:0] nh;
    nh = shift_in(h, s);
    return (fill + 1 >= int'(D)) && (nh == {D{~out}});
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 <= '0;
      m_s2 <= '0;
      m_out <= '0;
      m_chg <= '0;
      for (int c = 0; c < 2; c++) begin
        m_hist[c] <= '0;
        m_fill[c] <= 0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        m_hist[c] <= shift_in(m_hist[c], m_s2[c]);
        m_fill[c] <= (m_fill[c] >= int'(D)) ? int'(D) : m_fill[c] + 1;
        m_chg[c]  <= flips(m_hist[c], m_s2[c], m_out[c], m_fill[c]);
        if (flips(m_hist[c], m_s2[c], m_out[c], m_fill[c]))
          m_out[c] <= ~m_out[c];
      end
      m_s2 <= m_s1;
      m_s1 <= {sif.w_raw, sif.e_raw};
    end
  end

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sif.e_raw = 1'b0;
      sif.w_raw = 1'b0;
    end
  endtask

  task automatic test_reset;
    sif.e_raw = 1'b1;
    sif.w_raw = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({sif.w_chg, sif.e_chg, sif.w, sif.e} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 0000", {sif.w_chg, sif.e_chg, sif.w, sif.e});
    end
    tests_run++;
    if (dut.cnt_q[0] !== 8'd0 || dut.cnt_q[1] !== 8'd0) begin
      fails++;
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", dut.cnt_q[0], dut.cnt_q[1]);
    end
    reset_n = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      tests_run++;
      if (sif.e !== (c >= 6) || sif.e_chg !== (c == 6) || sif.w !== (c >= 6) || sif.w_chg !== (c == 6)) begin
        fails++;
        $display("FAIL reset_release_rise edge %0d: got e=%b e_chg=%b w=%b w_chg=%b expected e=w=%b chg=%b",
                 c, sif.e, sif.e_chg, sif.w, sif.w_chg, c >= 6, c == 6);
      end
    end
    idle(12);
  endtask

  task automatic test_clean_rise;
    for (int ph = 0; ph < 2; ph++) begin
      bit lvl;
      lvl = (ph == 0);
      @(negedge clk);
      sif.e_raw = lvl;
      sif.w_raw = 1'b0;
      for (int c = 1; c <= 9; c++) begin
        @(negedge clk);
        tests_run++;
        if (sif.e !== ((c >= 6) ? lvl : ~lvl) || sif.e_chg !== (c == 6) || sif.w !== 1'b0 || sif.w_chg !== 1'b0) begin
          fails++;
          $display("FAIL clean_%s edge %0d: got e=%b e_chg=%b w=%b w_chg=%b expected e=%b e_chg=%b w=0 w_chg=0",
                   lvl ? "rise" : "fall", c, sif.e, sif.e_chg, sif.w, sif.w_chg,
                   (c >= 6) ? lvl : ~lvl, c == 6);
        end
      end
    end
    idle(4);
  endtask

  task automatic test_glitch;
    int pulses;
    pulses = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (sif.e !== 1'b0) pulses++;
      if (sif.e_chg !== 1'b0) pulses++;
      sif.e_raw = (c < 3);
    end
    tests_run++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL glitch_leak: got %0d high samples of e/e_chg expected 0", pulses);
    end
    tests_run++;
    if (dut.cnt_q[0] !== 8'd0) begin
      fails++;
      $display("FAIL glitch_counter: got %0d expected 0", dut.cnt_q[0]);
    end
  endtask

  task automatic test_bounce;
    bit [5:0] pat;
    int       strobes;
    pat = 6'b101101;
    strobes = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (sif.e_chg === 1'b1) strobes++;
      tests_run++;
      if (sif.e !== (c >= 11)) begin
        fails++;
        $display("FAIL bounce_level cycle %0d: got %b expected %b", c, sif.e, c >= 11);
      end
      sif.e_raw = (c < 6) ? pat[5 - c] : 1'b1;
    end
    tests_run++;
    if (strobes != 1) begin
      fails++;
      $display("FAIL bounce_strobes: got %0d expected 1", strobes);
    end
    idle(10);
  endtask

  task automatic test_simultaneous;
    @(negedge clk);
    sif.e_raw = 1'b1;
    sif.w_raw = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      tests_run++;
      if ({sif.w, sif.e} !== {2{c >= 6}} || {sif.w_chg, sif.e_chg} !== {2{c == 6}}) begin
        fails++;
        $display("FAIL simultaneous edge %0d: got w,e=%b chg=%b expected %b chg=%b",
                 c, {sif.w, sif.e}, {sif.w_chg, sif.e_chg}, {2{c >= 6}}, {2{c == 6}});
      end
    end
    idle(10);
  endtask

  task automatic test_reset_mid_count;
    @(negedge clk);
    sif.e_raw = 1'b1;
    repeat (4) @(negedge clk);
    tests_run++;
    if (dut.cnt_q[0] !== 8'd2) begin
      fails++;
      $display("FAIL midcount_precondition: got cnt %0d expected 2", dut.cnt_q[0]);
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({sif.w_chg, sif.e_chg, sif.w, sif.e} !== 4'b0000 || dut.cnt_q[0] !== 8'd0 ||
        dut.s1_q !== 2'b00 || dut.s2_q !== 2'b00) begin
      fails++;
      $display("FAIL midcount_async_clear: got outs=%b cnt=%0d s1=%b s2=%b expected all 0",
               {sif.w_chg, sif.e_chg, sif.w, sif.e}, dut.cnt_q[0], dut.s1_q, dut.s2_q);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      tests_run++;
      if (sif.e !== (c >= 6) || sif.e_chg !== (c == 6)) begin
        fails++;
        $display("FAIL midcount_requalify edge %0d: got e=%b e_chg=%b expected e=%b e_chg=%b",
                 c, sif.e, sif.e_chg, c >= 6, c == 6);
      end
    end
    idle(10);
  endtask

  task automatic test_random;
    int unsigned noise;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      tests_run++;
      if ({sif.w_chg, sif.e_chg, sif.w, sif.e} !== {m_chg[1], m_chg[0], m_out[1], m_out[0]}) begin
        fails++;
        $display("FAIL random_model cycle %0d: got w_chg,e_chg,w,e=%b expected %b",
                 c, {sif.w_chg, sif.e_chg, sif.w, sif.e}, {m_chg[1], m_chg[0], m_out[1], m_out[0]});
      end
      noise = ((c / 50) % 2 == 0) ? 2 : 10;
      if ($urandom_range(noise - 1, 0) == 0) sif.e_raw = ~sif.e_raw;
      if ($urandom_range(noise - 1, 0) == 0) sif.w_raw = ~sif.w_raw;
    end
    idle(12);
  endtask

  initial begin
    clk = 1'b0;
    reset_n = 1'b0;
    sif.e_raw = 1'b0;
    sif.w_raw = 1'b0;
    tests_run = 0;
    fails = 0;
    test_reset();
    test_clean_rise();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_mid_count();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/sensor_conditioner.md
# sensor_conditioner

Input conditioning stage that sits directly upstream of the two-sensor sequence-detector FSM. It takes the raw, asynchronous `e_raw` and `w_raw` sensor lines and delivers clean, synchronous, debounced `e` and `w` levels for the FSM's `e`/`w` inputs. It also emits single-cycle change strobes. Both channels are identical and fully independent.

## Interface

Parameters:
- `DEBOUNCE`, default 4: number of consecutive clock edges that a synchronized level must differ from the current output before the output adopts it. Legal range 1..255.
- `CNT_W`, default 8: width of each debounce counter. Must satisfy 2^CNT_W > DEBOUNCE.

Ports:
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `e_raw`, input, 1: raw east sensor, asynchronous to `clk`, may bounce.
- `w_raw`, input, 1: raw west sensor, asynchronous to `clk`, may bounce.
- `e`, output, 1: debounced east level; connects to the FSM `e` input.
- `w`, output, 1: debounced west level; connects to the FSM `w` input.
- `e_chg`, output, 1: one-cycle strobe, high in the cycle after `e` changes value.
- `w_chg`, output, 1: one-cycle strobe, high in the cycle after `w` changes value.

## Operation

Each channel (described for E; W is identical) contains:
- A 2-flop synchronizer: `e_raw` -> `e_s1` -> `e_s2`.
- A debounce counter `e_cnt` of CNT_W bits.
- The output register `e` and the strobe register `e_chg`.

Per rising edge of `clk`:
- `e_chg` <= 0 by default.
- If `e_s2 == e`: `e_cnt` <= 0. The output holds.
- If `e_s2 != e` and `e_cnt == DEBOUNCE-1`: `e` <= `e_s2`, `e_cnt` <= 0, `e_chg` <= 1.
- If `e_s2 != e` and `e_cnt < DEBOUNCE-1`: `e_cnt` <= `e_cnt` + 1.

Rules:
- The counter never exceeds DEBOUNCE-1. No wrap-around is possible.
- Any single cycle with `e_s2 == e` restarts qualification from zero. Bounces therefore never leak through.
- Rising and falling transitions are qualified identically. Both produce a strobe.
- The channels share nothing. Simultaneous changes on E and W qualify in parallel, and both outputs update on the same edge when their histories are identical.
- With DEBOUNCE=1, the output follows `e_s2` one edge after the mismatch appears.

Reset (`reset_n` low, asynchronous, takes effect immediately without a clock edge):
- `e_s1`, `e_s2`, `w_s1`, `w_s2` = 0.
- `e_cnt`, `w_cnt` = 0.
- `e`, `w`, `e_chg`, `w_chg` = 0.

Reset mid-qualification discards the partial count. After release, a raw line already held high qualifies from scratch and produces a rising strobe.

The outputs idle at `e=0, w=0`. This is the FSM's no-sensor condition, so after reset the downstream FSM sees no activity until a level qualifies.

## Timing

- Let the edge that first samples a new raw level into `e_s1` be edge k.
  - `e_s2` reflects the new level after edge k+1.
  - The counter advances on edges k+2 .. k+DEBOUNCE.
  - `e` updates on edge k+1+DEBOUNCE.
  - `e_chg` is high for exactly the cycle following that edge.
- Latency is DEBOUNCE+2 edges from raw change to the output, counting the capture edge. With the default parameter, the output changes on edge k+5.
- A raw pulse shorter than DEBOUNCE cycles, as seen at `e_s2`, never changes `e` and never raises `e_chg`.
- Outputs are driven directly from flops, with no combinational path from any input. The FSM therefore samples stable values on the next edge.
- Reset release is synchronous to the design's own reset distribution. No output toggles in the first edge after release unless qualified.

## Test plan

- **Reset:** hold `reset_n`=0 with `e_raw=w_raw=1` and toggle `clk`.
  - Required: `e=w=e_chg=w_chg=0` and both counters 0.
  - Deassert reset: `e` rises exactly 6 edges later (DEBOUNCE=4).
- **Clean rise:** `e_raw` 0->1 before edge k, held high.
  - Required: `e`=1 after edge k+5, `e_chg`=1 for exactly that one cycle, `w` and `w_chg` stay 0.
  - Falling edge: `e_raw` 1->0 gives `e`=0 at k'+5 with one `e_chg` pulse.
- **Glitch rejection:** `e_raw` high for 3 cycles, then low.
  - Required: `e` stays 0, `e_chg` never asserts, `e_cnt` returns to 0.
- **Bounce:** `e_raw` pattern 1,0,1,1,0,1 followed by a steady 1.
  - Required: `e` rises only after 4 consecutive high samples at `e_s2`, with exactly one `e_chg` pulse.
- **Simultaneous:** `e_raw` and `w_raw` both 0->1 on the same cycle.
  - Required: `e` and `w` both rise at edge k+5, and `e_chg` and `w_chg` pulse together.
- **Reset mid-count:** assert `reset_n` low while `e_cnt`=2.
  - Required: all state is 0 immediately.
  - With `e_raw` still 1 after release, `e` rises 6 edges after release.
